effect_param_sequencer: RTL
===========================

# effect_param_sequencer

Central push-button parameter sequencer for the audio effects chain. It debounces the two user keys and steps a bounded parameter in one of four slots chosen by `SW[3:0]`. It computes the vibrato LFO period with a multi-cycle divider and delivers every committed change to the effect datapaths over a valid/ready update port. It sits between the board I/O and the vibrato and echo effect blocks, and replaces per-effect key handling.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced key state changes; the legal minimum is 2.
- `CLK`  in  1  system clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `key3`  in  1  decrement key, active low, asynchronous to `CLK`.
- `key2`  in  1  increment key, active low, asynchronous to `CLK`.
- `SW`  in  10  board switches. `SW[3:0]` selects the slot; `SW[5]` enables vibrato.
- `vib_rate`  out  4  slot 0, vibrato LFO rate in Hz, range 1..10.
- `vib_depth`  out  4  slot 1, vibrato maximum phase shift step, range 0..15.
- `echo_delay`  out  5  slot 2, echo delay step, range 1..16.
- `echo_fb`  out  3  slot 3, echo feedback step, range 0..7.
- `vib_period`  out  32  LFO half-period count, equal to floor(97656 / `vib_rate`), zero-extended.
- `vib_disabled`  out  1  registered copy of `~SW[5]`.
- `upd_valid`  out  1  a parameter update is offered.
- `upd_slot`  out  2  slot index of the offered update.
- `upd_value`  out  8  new slot value, zero-extended.
- `upd_ready`  in  1  the consumer accepts the update.

## Operation
- **Synchronizers:** each key passes through a 2-flop synchronizer. Both synchronizer flops reset to 1.
- **Debounce, per key:**
  - A counter clears whenever the synchronized input equals the debounced state.
  - Otherwise the counter increments.
  - When the count reaches `DEBOUNCE_CYCLES - 1`, the debounced state takes the synchronized value and the counter clears.
  - The debounced state resets to 1 (released).
- **Press event:** a one-cycle pulse on each 1→0 transition of the debounced state. A release generates no event.
- **Slot select (`SW[3:0]`):**
  - 6 selects slot 0.
  - 7 selects slot 1.
  - 8 selects slot 2.
  - 9 selects slot 3.
  - Any other value selects no slot; press events are then discarded.
- **FSM states:** IDLE, DIV, OFFER.
- **IDLE, press handling:**
  - A key2 event alone increments the selected value if it is below max; a key3 event alone decrements it if it is above min.
  - If the value changes: slot 0 goes to DIV; slots 1–3 go to OFFER.
  - If the value is saturated, there is no change, no transition and no update.
  - Simultaneous key2 and key3 events in the same cycle: both are discarded and the state stays IDLE.
- **DIV:** restoring divide of the constant 97656 by `vib_rate`, one quotient bit per cycle, 17 cycles.
  - The quotient is written to `vib_period` on the last cycle, and the state goes to OFFER.
  - The divisor is latched on entry.
- **OFFER:**
  - `upd_valid` = 1.
  - `upd_slot` and `upd_value` are held stable and `upd_value` is captured at the commit.
  - On `upd_valid` & `upd_ready`, the state goes to IDLE.
- **Events outside IDLE:** press events arriving in DIV or OFFER are dropped, not queued.
- **SW change mid-transaction:** has no effect on an in-flight update.
- **Slot registers:** change only at the IDLE commit. They are never written during DIV or OFFER.
- **`vib_disabled`:** updated every cycle, independent of the FSM.

## Timing
- **Reset values:**
  - `vib_rate` = 5, `vib_depth` = 8, `echo_delay` = 4, `echo_fb` = 3.
  - `vib_period` = 19531.
  - `vib_disabled` = 1.
  - `upd_valid` = 0, `upd_slot` = 0, `upd_value` = 0.
  - FSM = IDLE; debounce counters = 0.
- **Key latency:** a key held low from cycle t produces its press event at cycle t + 2 + `DEBOUNCE_CYCLES` (2 synchronizer cycles, then the debounce count).
- **Commit:** the slot register updates on the clock edge following the event cycle.
- **Slots 1–3:** `upd_valid` rises on the same edge as the commit.
- **Slot 0:** `vib_rate` updates on the commit edge. `vib_period` updates 17 cycles later, and `upd_valid` rises on that same edge.
- **Handshake:**
  - `upd_valid` is held until a cycle with `upd_ready` = 1, then falls on the next edge.
  - A new event is accepted no earlier than the cycle after `upd_valid` falls.
- **Reset mid-operation:** asserting `RESET_N` low immediately forces all reset values and aborts a divide or offer; no update is emitted.

## Test plan
1. **Reset and default period:** with `DEBOUNCE_CYCLES` = 4, release reset and hold `upd_ready` = 1 → outputs hold their reset values, `vib_period` = 19531, `upd_valid` = 0.
2. **Increment with divide:** `SW[3:0]` = 6, one key2 press → `vib_rate` = 6. 17 cycles later `vib_period` = 16276 and `upd_valid`, `upd_slot` = 0, `upd_value` = 6 appear.
3. **Saturation:** `SW[3:0]` = 6, press key3 five times → `vib_rate` = 1, `vib_period` = 97656, exactly 4 updates. Press key3 again → no change and no `upd_valid`.
4. **Backpressure:** `SW[3:0]` = 9, one key2 press, `upd_ready` = 0 for 50 cycles → `upd_valid` stays high with `upd_value` = 4 and `echo_fb` = 4. A second key2 press during the wait is dropped (`echo_fb` stays 4).
5. **Bounce, simultaneous and unmapped:**
   - `key2` toggling every 2 cycles → no event.
   - key2 and key3 events in the same cycle with `SW[3:0]` = 7 → `vib_depth` stays 8.
   - `SW[3:0]` = 3 with a key2 press → no update.
6. **Reset mid-divide:** assert `RESET_N` at DIV cycle 8 → `vib_rate` = 5, `vib_period` = 19531, `upd_valid` never asserted.

Source files
------------

// File: rtl/effect_param_sequencer.sv
// Push-button parameter sequencer: debounced keys step one of four effect parameters, with the vibrato period computed by a 17-cycle divider.
// Latency: key to press event is 2 + DEBOUNCE_CYCLES cycles; commit 1 cycle later; a slot-0 update is offered 17 cycles after its commit.
// Backpressure: the update is held until upd_ready; press events that arrive while an update is busy (dividing or offered) are dropped.
//
// Ports:
//   CLK, RESET_N        clock and asynchronous active-low reset
//   key2, key3          raw active-low increment / decrement keys (asynchronous to CLK)
//   SW[9:0]             SW[3:0] selects the slot (6..9 = slot 0..3); SW[5] enables vibrato
//   vib_rate, vib_depth, echo_delay, echo_fb   slot registers 0..3
//   vib_period          floor(97656 / vib_rate), zero-extended
//   vib_disabled        registered ~SW[5]
//   upd_valid/upd_ready/upd_slot/upd_value     parameter update port
module effect_param_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        key3,
   input  logic        key2,
   input  logic [9:0]  SW,
   output logic [3:0]  vib_rate,
   output logic [3:0]  vib_depth,
   output logic [4:0]  echo_delay,
   output logic [2:0]  echo_fb,
   output logic [31:0] vib_period,
   output logic        vib_disabled,
   output logic        upd_valid,
   output logic [1:0]  upd_slot,
   output logic [7:0]  upd_value,
   input  logic        upd_ready
);

   localparam int              CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [16:0]     DIVIDEND  = 17'd97656;
   localparam logic [31:0]     PERIOD_RST = 32'd19531;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_OFFER = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Key conditioning. Index 0 is key2 (increment), index 1 is key3
   // (decrement). Everything resets to 1 so a held key after reset still
   // has to go through the full debounce before producing an event.
   // ------------------------------------------------------------------
   logic [1:0]    key_raw;
   logic [1:0]    sync1_q;
   logic [1:0]    sync2_q;
   logic [1:0]    db_q;
   logic [1:0]    db_prev_q;
   logic [CW-1:0] cnt_q [2];
   logic [1:0]    press_ev;

   assign key_raw = {key3, key2};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q   <= 2'b11;
         sync2_q   <= 2'b11;
         db_q      <= 2'b11;
         db_prev_q <= 2'b11;
         for (int k = 0; k < 2; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         sync1_q   <= key_raw;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == db_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] == CNT_MAX) begin
               db_q[k]  <= sync2_q[k];
               cnt_q[k] <= '0;
            end else begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Falling edge of the debounced level is a press; releases are ignored.
   assign press_ev = db_prev_q & ~db_q;

   // ------------------------------------------------------------------
   // Slot decode
   // ------------------------------------------------------------------
   logic       sel_vld;
   logic [1:0] sel_slot;
   logic       unused_sw;

   assign unused_sw = ^{SW[9:6], SW[4]};

   always_comb begin
      sel_vld  = 1'b1;
      sel_slot = 2'd0;
      case (SW[3:0])
         4'd6:    sel_slot = 2'd0;
         4'd7:    sel_slot = 2'd1;
         4'd8:    sel_slot = 2'd2;
         4'd9:    sel_slot = 2'd3;
         default: sel_vld  = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t      state_q,      state_d;
   logic [3:0]  vib_rate_q,   vib_rate_d;
   logic [3:0]  vib_depth_q,  vib_depth_d;
   logic [4:0]  echo_delay_q, echo_delay_d;
   logic [2:0]  echo_fb_q,    echo_fb_d;
   logic [31:0] vib_period_q, vib_period_d;
   logic [1:0]  upd_slot_q,   upd_slot_d;
   logic [7:0]  upd_value_q,  upd_value_d;
   logic [3:0]  divisor_q,    divisor_d;
   logic [3:0]  rem_q,        rem_d;
   logic [16:0] dq_q,         dq_d;      // dividend shifts out, quotient shifts in
   logic [4:0]  bit_cnt_q,    bit_cnt_d;
   logic        vib_dis_q;

   // Current value and bounds of the selected slot, widened to 8 bits.
   logic [7:0] cur_val;
   logic [7:0] min_val;
   logic [7:0] max_val;

   always_comb begin
      cur_val = 8'd0;
      min_val = 8'd0;
      max_val = 8'd0;
      case (sel_slot)
         2'd0: begin
            cur_val = {4'd0, vib_rate_q};
            min_val = 8'd1;
            max_val = 8'd10;
         end
         2'd1: begin
            cur_val = {4'd0, vib_depth_q};
            min_val = 8'd0;
            max_val = 8'd15;
         end
         2'd2: begin
            cur_val = {3'd0, echo_delay_q};
            min_val = 8'd1;
            max_val = 8'd16;
         end
         default: begin
            cur_val = {5'd0, echo_fb_q};
            min_val = 8'd0;
            max_val = 8'd7;
         end
      endcase
   end

   // One restoring-division step: shift the next dividend bit into the
   // remainder and subtract the divisor when it fits. The remainder is
   // always below the divisor (<= 10), so 4 bits hold it between steps.
   logic [4:0] rem_sh;
   logic       div_ge;

   assign rem_sh = {rem_q, dq_q[16]};
   assign div_ge = (rem_sh >= {1'b0, divisor_q});

   logic       chg;
   logic [7:0] new_val;

   always_comb begin
      state_d      = state_q;
      vib_rate_d   = vib_rate_q;
      vib_depth_d  = vib_depth_q;
      echo_delay_d = echo_delay_q;
      echo_fb_d    = echo_fb_q;
      vib_period_d = vib_period_q;
      upd_slot_d   = upd_slot_q;
      upd_value_d  = upd_value_q;
      divisor_d    = divisor_q;
      rem_d        = rem_q;
      dq_d         = dq_q;
      bit_cnt_d    = bit_cnt_q;
      chg          = 1'b0;
      new_val      = cur_val;

      case (state_q)
         ST_IDLE: begin
            // Exactly one of the two events; a simultaneous pair cancels out.
            if (sel_vld && (press_ev[0] ^ press_ev[1])) begin
               if (press_ev[0] && (cur_val < max_val)) begin
                  new_val = cur_val + 8'd1;
                  chg     = 1'b1;
               end else if (press_ev[1] && (cur_val > min_val)) begin
                  new_val = cur_val - 8'd1;
                  chg     = 1'b1;
               end
            end
            if (chg) begin
               upd_slot_d  = sel_slot;
               upd_value_d = new_val;
               case (sel_slot)
                  2'd0:    vib_rate_d   = new_val[3:0];
                  2'd1:    vib_depth_d  = new_val[3:0];
                  2'd2:    echo_delay_d = new_val[4:0];
                  default: echo_fb_d    = new_val[2:0];
               endcase
               if (sel_slot == 2'd0) begin
                  state_d   = ST_DIV;
                  divisor_d = new_val[3:0];
                  rem_d     = 4'd0;
                  dq_d      = DIVIDEND;
                  bit_cnt_d = 5'd0;
               end else begin
                  state_d = ST_OFFER;
               end
            end
         end

         ST_DIV: begin
            rem_d     = div_ge ? 4'(rem_sh - {1'b0, divisor_q}) : rem_sh[3:0];
            dq_d      = {dq_q[15:0], div_ge};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd16) begin
               vib_period_d = {15'd0, dq_q[15:0], div_ge};
               state_d      = ST_OFFER;
            end
         end

         ST_OFFER: begin
            if (upd_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         vib_rate_q   <= 4'd5;
         vib_depth_q  <= 4'd8;
         echo_delay_q <= 5'd4;
         echo_fb_q    <= 3'd3;
         vib_period_q <= PERIOD_RST;
         upd_slot_q   <= 2'd0;
         upd_value_q  <= 8'd0;
         divisor_q    <= 4'd5;
         rem_q        <= 4'd0;
         dq_q         <= 17'd0;
         bit_cnt_q    <= 5'd0;
         vib_dis_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         vib_rate_q   <= vib_rate_d;
         vib_depth_q  <= vib_depth_d;
         echo_delay_q <= echo_delay_d;
         echo_fb_q    <= echo_fb_d;
         vib_period_q <= vib_period_d;
         upd_slot_q   <= upd_slot_d;
         upd_value_q  <= upd_value_d;
         divisor_q    <= divisor_d;
         rem_q        <= rem_d;
         dq_q         <= dq_d;
         bit_cnt_q    <= bit_cnt_d;
         vib_dis_q    <= ~SW[5];
      end
   end

   assign vib_rate     = vib_rate_q;
   assign vib_depth    = vib_depth_q;
   assign echo_delay   = echo_delay_q;
   assign echo_fb      = echo_fb_q;
   assign vib_period   = vib_period_q;
   assign vib_disabled = vib_dis_q;
   assign upd_valid    = (state_q == ST_OFFER);
   assign upd_slot     = upd_slot_q;
   assign upd_value    = upd_value_q;

endmodule
